// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and sizing helpers for the two-requester round-robin mux arbiter.
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    function automatic int cnt_w(input int burst);
        return $clog2(burst) + 1;
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Stream bundle for the arbiter: two producer ports, one consumer port, mux select.
interface mux2_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             sel;

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, sel
    );

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, sel
    );
endinterface

// File: rtl/mux2_rr_fsm.sv
// Grant state machine: tracks owner, last winner and burst length; drives mux select.
module mux2_rr_fsm
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       v0,
    input  logic       v1,
    input  logic       acc0,
    input  logic       acc1,
    output logic [1:0] grant,
    output logic       sel
);
    localparam int CW = cnt_w(BURST);
    localparam logic [CW-1:0] CMAX = CW'(BURST - 1);

    arb_state_t    state, state_n;
    logic          last, last_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          sel_n;
    logic          cur, cur_v, oth_v, cur_acc;
    logic          rel_a, rel_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
            sel   <= 1'b0;
        end else begin
            state <= state_n;
            last  <= last_n;
            cnt   <= cnt_n;
            sel   <= sel_n;
        end
    end

    assign cur     = (state == GRANT1);
    assign cur_v   = cur ? v1 : v0;
    assign oth_v   = cur ? v0 : v1;
    assign cur_acc = cur ? acc1 : acc0;

    always_comb begin
        state_n = state;
        last_n  = last;
        cnt_n   = cnt;
        sel_n   = sel;
        rel_a   = 1'b0;
        rel_b   = 1'b0;
        unique case (state)
            IDLE: begin
                if (v0 || v1) begin
                    sel_n   = (v0 && v1) ? !last : v1;
                    state_n = sel_n ? GRANT1 : GRANT0;
                    cnt_n   = '0;
                end
            end
            GRANT0, GRANT1: begin
                if (cur_acc)
                    cnt_n = cnt + CW'(1);
                rel_a = cur_acc && (cnt == CMAX);
                rel_b = !cur_v;
                if (rel_a || rel_b) begin
                    last_n = cur;
                    if (oth_v) begin
                        state_n = cur ? GRANT0 : GRANT1;
                        sel_n   = !cur;
                        cnt_n   = '0;
                    end else if (rel_a) begin
                        // uncontended: keep the grant, restart the burst
                        cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign grant = {state == GRANT1, state == GRANT0};
endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin shared 2:1 mux with a single-entry registered output stage.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input logic           clk,
    input logic           rst_n,
    mux2_rr_arbiter_if.slave bus
);
    logic [1:0]       grant;
    logic             sel;
    logic             free, acc0, acc1, load;
    logic [WIDTH-1:0] beat;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    mux2_rr_fsm #(.BURST(BURST)) u_fsm (
        .clk   (clk),
        .rst_n (rst_n),
        .v0    (bus.in0_valid),
        .v1    (bus.in1_valid),
        .acc0  (acc0),
        .acc1  (acc1),
        .grant (grant),
        .sel   (sel)
    );

    assign free = !valid_q || bus.out_ready;
    assign bus.in0_ready = grant[0] && free;
    assign bus.in1_ready = grant[1] && free;
    assign acc0 = bus.in0_valid && bus.in0_ready;
    assign acc1 = bus.in1_valid && bus.in1_ready;
    assign load = acc0 || acc1;
    assign beat = sel ? bus.in1_data : bus.in0_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= beat;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.sel       = sel;
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scenario bench for mux2_rr_arbiter against a transaction-level reference model.
module tb_mux2_rr_arbiter;
    localparam int W = 8;
    localparam int B = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    mux2_rr_arbiter_if #(.WIDTH(W)) bus ();

    mux2_rr_arbiter #(.WIDTH(W), .BURST(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference model: owner is -1 when nobody holds the grant
    int         m_owner, m_beats, m_last, m_sel;
    logic       m_ov;
    logic [7:0] m_od;
    logic       mr0, mr1, m_a0, m_a1;
    logic       o_r0, o_r1;
    logic [7:0] seen[$];

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_last = 1;
        m_sel = 0; m_ov = 1'b0; m_od = 8'h00;
        seen.delete();
    endtask

    task automatic model_edge(input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1,
                              input logic ordy);
        int k, pick;
        logic vk, vo, ak;
        m_a0 = v0 && mr0;
        m_a1 = v1 && mr1;
        if (m_a0 || m_a1) begin
            m_ov = 1'b1;
            m_od = m_a0 ? d0 : d1;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        if (m_owner < 0) begin
            pick = -1;
            if (v0 && v1) pick = 1 - m_last;
            else if (v0) pick = 0;
            else if (v1) pick = 1;
            if (pick >= 0) begin
                m_owner = pick; m_beats = 0; m_sel = pick;
            end
        end else begin
            k  = m_owner;
            vk = k ? v1 : v0;
            vo = k ? v0 : v1;
            ak = k ? m_a1 : m_a0;
            if (ak) m_beats++;
            if ((ak && m_beats == B) || !vk) begin
                m_last = k;
                if (vo) begin
                    m_owner = 1 - k; m_beats = 0; m_sel = 1 - k;
                end else if (vk) begin
                    m_beats = 0;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic step(input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1,
                        input logic ordy);
        logic pre_ov;
        @(negedge clk);
        bus.in0_valid = v0; bus.in0_data = d0;
        bus.in1_valid = v1; bus.in1_data = d1;
        bus.out_ready = ordy;
        #1;
        mr0 = (m_owner == 0) && (!m_ov || ordy);
        mr1 = (m_owner == 1) && (!m_ov || ordy);
        o_r0 = bus.in0_ready;
        o_r1 = bus.in1_ready;
        pre_ov = bus.out_valid;
        @(posedge clk);
        model_edge(v0, d0, v1, d1, ordy);
        #1;
        if (bus.out_valid && (!pre_ov || ordy))
            seen.push_back(bus.out_data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in0_valid = 0; bus.in0_data = 0;
        bus.in1_valid = 0; bus.in1_data = 0;
        bus.out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] cont_val(input int i);
        int g;
        g = i / B;
        return 8'(((g % 2) ? 8'hB0 : 8'hA0) + (g / 2) * B + (i % B));
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in0_valid = 1; bus.in1_valid = 1;
        bus.in0_data = 8'h55; bus.in1_data = 8'h66;
        bus.out_ready = 1;
        #1;
        n_tests++;
        if ({bus.in0_ready, bus.in1_ready, bus.out_valid, bus.sel} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got r0=%b r1=%b ov=%b sel=%b want 0",
                     bus.in0_ready, bus.in1_ready, bus.out_valid, bus.sel);
        end
        n_tests++;
        if (bus.out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data got %h want 00", bus.out_data);
        end
        do_reset();
    endtask

    task automatic test_single();
        int idx = 0;
        int first = -1, cnt_ov = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(idx < 6, 8'(8'h10 + idx), 1'b0, 8'h00, 1'b1);
            if (m_a0) idx++;
            n_tests++;
            if (bus.sel !== 1'b0) begin
                n_fail++;
                $display("FAIL single_sel got %b want 0", bus.sel);
            end
            if (bus.out_valid) begin
                if (first < 0) first = c;
                cnt_ov++;
            end
        end
        n_tests++;
        if (seen.size() != 6 || first != 1 || cnt_ov != 6) begin
            n_fail++;
            $display("FAIL single_seq got n=%0d first=%0d ov=%0d want 6 1 6",
                     seen.size(), first, cnt_ov);
        end
        for (int i = 0; i < seen.size() && i < 6; i++) begin
            n_tests++;
            if (seen[i] !== 8'(8'h10 + i)) begin
                n_fail++;
                $display("FAIL single_beat%0d got %h want %h",
                         i, seen[i], 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_contention();
        int a = 0, b = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 8'(8'hA0 + a), 1'b1, 8'(8'hB0 + b), 1'b1);
            if (m_a0) a++;
            if (m_a1) b++;
            if (c == 0) begin
                n_tests++;
                if (bus.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tie_early_ov got %b want 0", bus.out_valid);
                end
            end
            if (c == 1) begin
                n_tests++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA0) begin
                    n_fail++;
                    $display("FAIL tie_first got ov=%b d=%h want 1 a0",
                             bus.out_valid, bus.out_data);
                end
            end
            if (c >= 1) begin
                n_tests++;
                if (bus.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cont_gap cycle %0d got ov=0 want 1", c);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (i >= seen.size() || seen[i] !== cont_val(i)) begin
                n_fail++;
                $display("FAIL cont_beat%0d got %h want %h", i,
                         (i < seen.size()) ? seen[i] : 8'hxx, cont_val(i));
            end
        end
    endtask

    task automatic test_backpressure();
        int a = 0, b = 0;
        logic ordy;
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            ordy = !(c >= 4 && c <= 6);
            step(1'b1, 8'(8'hA0 + a), 1'b1, 8'(8'hB0 + b), ordy);
            if (m_a0) a++;
            if (m_a1) b++;
            if (!ordy) begin
                n_tests++;
                if (o_r0 !== 1'b0 || bus.out_data !== 8'hA1) begin
                    n_fail++;
                    $display("FAIL bp_stall c=%0d got r0=%b d=%h want 0 a1",
                             c, o_r0, bus.out_data);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (i >= seen.size() || seen[i] !== cont_val(i)) begin
                n_fail++;
                $display("FAIL bp_beat%0d got %h want %h", i,
                         (i < seen.size()) ? seen[i] : 8'hxx, cont_val(i));
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        step(1'b0, 8'hA0, 1'b1, 8'hB0, 1'b1);
        step(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
        step(1'b1, 8'hA0, 1'b1, 8'hB1, 1'b1);
        step(1'b1, 8'hA0, 1'b0, 8'hB2, 1'b1);
        n_tests++;
        if (bus.sel !== 1'b0 || dut.u_fsm.last !== 1'b1) begin
            n_fail++;
            $display("FAIL early_rel got sel=%b last=%b want 0 1",
                     bus.sel, dut.u_fsm.last);
        end
        step(1'b1, 8'hA0, 1'b0, 8'hB2, 1'b1);
        n_tests++;
        if (o_r0 !== 1'b1 || bus.out_data !== 8'hA0) begin
            n_fail++;
            $display("FAIL early_next got r0=%b d=%h want 1 a0",
                     o_r0, bus.out_data);
        end
        n_tests++;
        if (seen.size() < 3 || seen[0] !== 8'hB0 || seen[1] !== 8'hB1) begin
            n_fail++;
            $display("FAIL early_seq got n=%0d want B0 B1 A0", seen.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b0, 8'h00, 1'b1, 8'hC0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'hC0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'hC1, 1'b1);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.sel !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre got ov=%b sel=%b want 1 1",
                     bus.out_valid, bus.sel);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.out_valid, bus.sel, bus.in0_ready, bus.in1_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL rmid_clear got ov=%b sel=%b r0=%b r1=%b want 0",
                     bus.out_valid, bus.sel, bus.in0_ready, bus.in1_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'hD0, 1'b1);
        n_tests++;
        if (o_r1 !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_idle got r1=%b ov=%b want 0 0",
                     o_r1, bus.out_valid);
        end
        step(1'b0, 8'h00, 1'b1, 8'hD0, 1'b1);
        n_tests++;
        if (o_r1 !== 1'b1 || bus.out_data !== 8'hD0) begin
            n_fail++;
            $display("FAIL rmid_regrant got r1=%b d=%h want 1 d0",
                     o_r1, bus.out_data);
        end
    endtask

    task automatic test_random();
        logic v0, v1, ordy;
        logic [7:0] d0, d1;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            step(v0, d0, v1, d1, ordy);
            n_tests++;
            if (o_r0 !== mr0 || o_r1 !== mr1) begin
                n_fail++;
                $display("FAIL rnd_ready c=%0d got %b%b want %b%b",
                         c, o_r0, o_r1, mr0, mr1);
            end
            n_tests++;
            if (bus.out_valid !== m_ov || bus.out_data !== m_od) begin
                n_fail++;
                $display("FAIL rnd_out c=%0d got %b/%h want %b/%h",
                         c, bus.out_valid, bus.out_data, m_ov, m_od);
            end
            n_tests++;
            if (bus.sel !== 1'(m_sel)) begin
                n_fail++;
                $display("FAIL rnd_sel c=%0d got %b want %0d",
                         c, bus.sel, m_sel);
            end
        end
    endtask

    initial begin
        bus.in0_valid = 0; bus.in0_data = 0;
        bus.in1_valid = 0; bus.in1_data = 0;
        bus.out_ready = 0;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_release();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
